// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: sequences start/data/parity/stop bit periods and strobes a PISO shift register.
// Optional parity bit is compiled in with `define UART_TX_PARITY_EN.
module uart_tx_ctrl #(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_busy,
    output logic       o_done,
    output logic       sr_load,
    output logic [8:0] sr_data,
    output logic       sr_shift_en
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    // shift strobe is registered, so it is armed one count before the last one
    localparam logic [CNT_W-1:0] SHIFT_ARM = CNT_W'(CLKS_PER_BIT - 2);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t           state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;

    function automatic logic frame_bit8(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
        return (^d) ^ PARITY_ODD;
`else
        // no parity: the ninth bit is simply the idle/stop level
        return 1'b1 | ((^d) ^ PARITY_ODD);
`endif
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            baud_cnt    <= '0;
            bit_cnt     <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            sr_load     <= 1'b0;
            sr_shift_en <= 1'b0;
            sr_data     <= 9'h1FF;
        end else begin
            sr_load     <= 1'b0;
            o_done      <= 1'b0;
            sr_shift_en <= (state != IDLE) && (baud_cnt == SHIFT_ARM);

            if (state != IDLE) begin
                baud_cnt <= sr_shift_en ? '0 : baud_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (i_valid) begin
                        sr_data  <= {frame_bit8(i_data), i_data};
                        sr_load  <= 1'b1;
                        o_busy   <= 1'b1;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= START;
                    end
                end
                START: begin
                    if (sr_shift_en) state <= DATA;
                end
                DATA: begin
                    if (sr_shift_en) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (sr_shift_en) state <= STOP;
                end
`endif
                STOP: begin
                    if (sr_shift_en) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: even- and odd-parity instances against a frame-offset reference model,
// directed frames followed by randomized traffic with occasional resets.
module tb_uart_tx_ctrl;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB  = 11;
    localparam bit PAR = 1'b1;
`else
    localparam int NB  = 10;
    localparam bit PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       i_valid = 1'b0;
    logic [7:0] i_data = 8'h00;

    logic       o_busy_e, o_done_e, sr_load_e, sr_shift_en_e;
    logic [8:0] sr_data_e;
    logic       o_busy_o, o_done_o, sr_load_o, sr_shift_en_o;
    logic [8:0] sr_data_o;

    uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b0)) dut_even (
        .clk(clk), .reset(reset), .i_data(i_data), .i_valid(i_valid),
        .o_busy(o_busy_e), .o_done(o_done_e), .sr_load(sr_load_e),
        .sr_data(sr_data_e), .sr_shift_en(sr_shift_en_e)
    );

    uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b1)) dut_odd (
        .clk(clk), .reset(reset), .i_data(i_data), .i_valid(i_valid),
        .o_busy(o_busy_o), .o_done(o_done_o), .sr_load(sr_load_o),
        .sr_data(sr_data_o), .sr_shift_en(sr_shift_en_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] frame_word(input logic [7:0] d, input bit odd);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += d[i];
        if (PAR) return {1'b0 ^ ((ones % 2) == 1) ^ odd, d};
        return {1'b1, d};
    endfunction

    // Reference: a frame is an offset counter from its load cycle; everything follows from the offset.
    int         cyc = 0;
    bit         m_on = 0, m_busy = 0, m_done = 0;
    int         m_off = 0;
    logic [8:0] m_de = 9'h1FF, m_do = 9'h1FF;

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            m_on = 1; m_busy = 0; m_done = 0; m_off = 0;
            m_de = 9'h1FF; m_do = 9'h1FF;
        end else if (m_busy) begin
            m_off++;
            m_done = (m_off == NB * CPB);
            if (m_done) m_busy = 0;
        end else begin
            m_done = 0;
            if (i_valid) begin
                m_busy = 1; m_off = 0;
                m_de = frame_word(i_data, 1'b0);
                m_do = frame_word(i_data, 1'b1);
            end
        end
    end

    int load_cnt = 0, done_cnt = 0, shift_cnt = 0;
    int load_cyc = 0, done_cyc = 0, first_shift_cyc = 0;

    always @(negedge clk) begin
        if (m_on) begin
            check_val("busy",      o_busy_e, m_busy);
            check_val("busy_odd",  o_busy_o, m_busy);
            check_val("load",      sr_load_e, m_busy && m_off == 0);
            check_val("shift",     sr_shift_en_e, m_busy && (m_off % CPB) == CPB - 1);
            check_val("shift_odd", sr_shift_en_o, m_busy && (m_off % CPB) == CPB - 1);
            check_val("done",      o_done_e, m_done);
            check_val("done_odd",  o_done_o, m_done);
            check_val("data_even", sr_data_e, m_de);
            check_val("data_odd",  sr_data_o, m_do);
            if (sr_load_e) begin load_cnt++; load_cyc = cyc; shift_cnt = 0; end
            if (sr_shift_en_e) begin
                if (shift_cnt == 0) first_shift_cyc = cyc;
                shift_cnt++;
            end
            if (o_done_e) begin done_cnt++; done_cyc = cyc; end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        i_data = d; i_valid = 1'b1;
        step();
        i_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < budget) begin step(); n++; end
        check_val("done_seen", done_cnt != d0, 1);
    endtask

    task automatic check_frame(input string tag);
        check_val({tag, "_pulses"}, shift_cnt, NB);
        check_val({tag, "_first_shift"}, first_shift_cyc - load_cyc, CPB - 1);
        check_val({tag, "_done_at"}, done_cyc - load_cyc, NB * CPB);
    endtask

    initial begin
        int lc, dc, d_at;
        repeat (3) step();
        check_val("rst_busy", o_busy_e, 0);
        check_val("rst_data", sr_data_e, 9'h1FF);
        check_val("rst_shift", sr_shift_en_e, 0);
        reset = 1'b0;
        step();

        send(8'hA5);
        check_val("a5_load", sr_load_e, 1);
        wait_done(200);
        check_val("a5_word", sr_data_e, PAR ? 9'h0A5 : 9'h1A5);
        check_frame("a5");
        step();

        send(8'h01);
        wait_done(200);
        check_val("01_even", sr_data_e, 9'h101);
        check_val("01_odd",  sr_data_o, PAR ? 9'h001 : 9'h101);
        step();

        send(8'h3C);
        wait_done(200);
        check_val("3c_word", sr_data_e, PAR ? 9'h03C : 9'h13C);
        check_frame("3c");

        // valid held high: next frame accepted in the done cycle
        i_data = 8'h55; i_valid = 1'b1;
        step();
        wait_done(200);
        d_at = done_cyc;
        step();
        check_val("b2b_load_at", load_cyc, d_at + 1);
        i_valid = 1'b0;
        wait_done(200);
        check_val("b2b_word", sr_data_e, PAR ? 9'h055 : 9'h155);
        step();

        // request during a frame is dropped
        lc = load_cnt;
        send(8'h5A);
        repeat (9) step();
        i_data = 8'hFF; i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        check_val("ignore_data", sr_data_e, PAR ? 9'h05A : 9'h15A);
        wait_done(200);
        repeat (10) step();
        check_val("ignore_frames", load_cnt, lc + 1);

        // reset mid-frame
        send(8'h77);
        dc = done_cnt;
        repeat (18) step();
        reset = 1'b1;
        step();
        check_val("abort_busy", o_busy_e, 0);
        check_val("abort_data", sr_data_e, 9'h1FF);
        reset = 1'b0;
        repeat (60) step();
        check_val("abort_no_done", done_cnt, dc);
        send(8'h81);
        wait_done(200);
        check_val("after_abort_word", sr_data_e, PAR ? 9'h081 : 9'h181);
        check_frame("after_abort");

        for (int i = 0; i < 1500; i++) begin
            i_valid = ($urandom_range(0, 3) == 0);
            i_data  = 8'($urandom);
            reset   = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 1'b0; i_valid = 1'b0;
        repeat (60) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "time limit");
    end

endmodule
